// File: rtl/move_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : move_pkg
//  Description : Shared types for the scroll-tile move sequencer. Contains the
//                direction and state encodings, the grid geometry and the
//                button priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package move_pkg;

  localparam int GRID_ROWS = 4;
  localparam int GRID_COLS = 6;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Buttons are packed so that bit index equals the dir_t value, which
  // makes the fixed priority up > down > left > right a lowest-bit-first scan.
  function automatic dir_t prioDir(input logic [3:0] btn);
    if (btn[0]) return DIR_UP;
    else if (btn[1]) return DIR_DOWN;
    else if (btn[2]) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running modulo-TICK_DIV counter that emits a one-cycle
//                tick on the last count while enabled.
//  Ports       : clk  - system clock
//                clr  - synchronous counter clear (wins over en)
//                en   - count enable
//                tick - high while enabled and the count is TICK_DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = en && (r_count == c_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Validates direction presses against the grid enables, runs
//                the slide animation, strobes commit and buffers one press
//                that arrives while a move is in flight.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                btn_up/down/left/right   - one-cycle press pulses
//                up/down/left/right_en    - aggregated move enables
//                move_dir                 - active direction, held when idle
//                move_active              - slide animation running
//                step_strobe              - pulse on each offset advance
//                offset                   - slide offset in pixels
//                commit                   - pulse: tiles latch new positions
//                busy                     - sequencer not idle
//                pend_valid               - a buffered press is waiting
//  Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer
  import move_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int TILE_PX  = 32,
  parameter int STEP_PX  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         up_en,
  input  logic                         down_en,
  input  logic                         left_en,
  input  logic                         right_en,
  output dir_t                         move_dir,
  output logic                         move_active,
  output logic                         step_strobe,
  output logic [$clog2(TILE_PX+1)-1:0] offset,
  output logic                         commit,
  output logic                         busy,
  output logic                         pend_valid
);

  localparam int OFF_W = $clog2(TILE_PX + 1);

  state_t           r_state, w_nextState;
  dir_t             r_moveDir, r_pendDir, w_btnDir, w_startDir;
  logic             r_pendValid;
  logic [OFF_W-1:0] r_offset;
  logic [3:0]       w_btn, w_en;
  logic             w_btnAny, w_tick, w_lastStep;
  logic             w_start, w_pendLoad, w_pendClr;

  // Bit index matches the dir_t encoding so enables can be indexed by direction.
  assign w_btn    = {btn_right, btn_left, btn_down, btn_up};
  assign w_en     = {right_en, left_en, down_en, up_en};
  assign w_btnAny = |w_btn;
  assign w_btnDir = prioDir(w_btn);

  // The advance that would reach a full tile ends the slide instead.
  assign w_lastStep = (int'(r_offset) + STEP_PX) >= TILE_PX;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tickDivider (
    .clk  (clk),
    .clr  (rst || w_start),
    .en   (r_state == MOVE),
    .tick (w_tick)
  );

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_startDir  = r_moveDir;
    w_pendLoad  = 1'b0;
    w_pendClr   = 1'b0;
    case (r_state)
      IDLE: begin
        // A press buffered during SETTLE is serviced here before new presses.
        if (r_pendValid) begin
          w_pendClr = 1'b1;
          if (w_en[r_pendDir]) begin
            w_start    = 1'b1;
            w_startDir = r_pendDir;
          end
        end else if (w_btnAny && w_en[w_btnDir]) begin
          w_start    = 1'b1;
          w_startDir = w_btnDir;
        end
      end
      MOVE: begin
        w_pendLoad = w_btnAny && !r_pendValid;
        if (w_tick && w_lastStep) begin
          w_nextState = COMMIT;
        end
      end
      COMMIT: begin
        w_pendLoad  = w_btnAny && !r_pendValid;
        w_nextState = SETTLE;
      end
      SETTLE: begin
        w_nextState = IDLE;
        if (r_pendValid) begin
          // Any press arriving while the pending entry is consumed is dropped.
          w_pendClr = 1'b1;
          if (w_en[r_pendDir]) begin
            w_start    = 1'b1;
            w_startDir = r_pendDir;
          end
        end else begin
          w_pendLoad = w_btnAny;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (w_start) begin
      w_nextState = MOVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_moveDir   <= DIR_UP;
      r_pendValid <= 1'b0;
      r_pendDir   <= DIR_UP;
      r_offset    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_start) begin
        r_moveDir <= w_startDir;
      end
      if (w_pendLoad) begin
        r_pendValid <= 1'b1;
        r_pendDir   <= w_btnDir;
      end else if (w_pendClr) begin
        r_pendValid <= 1'b0;
      end
      // Offset holds TILE_PX-STEP_PX through the final step, then returns to 0.
      if (r_state == MOVE && w_tick) begin
        r_offset <= w_lastStep ? '0 : r_offset + OFF_W'(STEP_PX);
      end
    end
  end

  assign move_dir    = r_moveDir;
  assign move_active = (r_state == MOVE);
  assign step_strobe = (r_state == MOVE) && w_tick && !w_lastStep;
  assign offset      = r_offset;
  assign commit      = (r_state == COMMIT);
  assign busy        = (r_state != IDLE);
  assign pend_valid  = r_pendValid;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Self-checking bench for move_sequencer with a cycle-count
//                based reference model and directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;
  import move_pkg::*;

  localparam int D    = 4;
  localparam int TILE = 8;
  localparam int STEP = 2;
  localparam int TOT  = (TILE / STEP) * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic up_en = 1'b1, down_en = 1'b1, left_en = 1'b1, right_en = 1'b1;
  dir_t move_dir;
  logic move_active, step_strobe, commit, busy, pend_valid;
  logic [3:0] offset;

  always #5 clk = ~clk;

  move_sequencer #(
    .TICK_DIV (D),
    .TILE_PX  (TILE),
    .STEP_PX  (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .up_en       (up_en),
    .down_en     (down_en),
    .left_en     (left_en),
    .right_en    (right_en),
    .move_dir    (move_dir),
    .move_active (move_active),
    .step_strobe (step_strobe),
    .offset      (offset),
    .commit      (commit),
    .busy        (busy),
    .pend_valid  (pend_valid)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a move is "elapsed cycles since start"; the phases
  // (slide, commit, settle) follow from that count alone.
  bit   mIn;
  int   mT;
  dir_t mDir;
  bit   mPv;
  dir_t mPd;

  // Observation records for directed tests, indexed by cycle.
  int cyc;
  int nCommit;
  int actA [64], strA [64], offA [64], comA [64], busyA [64], pvA [64], dirA [64];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int firstDir(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic compareAll();
    bit sliding;
    sliding = mIn && (mT < TOT);
    chk("move_dir",    int'(move_dir),    int'(mDir));
    chk("move_active", int'(move_active), int'(sliding));
    chk("step_strobe", int'(step_strobe), int'(sliding && (mT < TOT - 1) && (mT % D == D - 1)));
    chk("offset",      int'(offset),      sliding ? STEP * (mT / D) : 0);
    chk("commit",      int'(commit),      int'(mIn && mT == TOT));
    chk("busy",        int'(busy),        int'(mIn));
    chk("pend_valid",  int'(pend_valid),  int'(mPv));
  endtask

  task automatic modelUpdate(input logic [3:0] b, input logic [3:0] e, input logic r);
    dir_t bd;
    bd = dir_t'(firstDir(b));
    if (r) begin
      mIn = 0; mT = 0; mDir = DIR_UP; mPv = 0; mPd = DIR_UP;
    end else if (!mIn) begin
      if (mPv) begin
        mPv = 0;
        if (e[mPd]) begin mIn = 1; mT = 0; mDir = mPd; end
      end else if (b != 0 && e[bd]) begin
        mIn = 1; mT = 0; mDir = bd;
      end
    end else if (mT == TOT + 1) begin
      if (mPv) begin
        mPv = 0;
        if (e[mPd]) begin mT = 0; mDir = mPd; end
        else mIn = 0;
      end else begin
        mIn = 0;
        if (b != 0) begin mPv = 1; mPd = bd; end
      end
    end else begin
      if (b != 0 && !mPv) begin mPv = 1; mPd = bd; end
      mT++;
    end
  endtask

  // btn/en bit order: {right, left, down, up}
  task automatic step(input logic [3:0] b, input logic [3:0] e, input logic r);
    @(negedge clk);
    compareAll();
    if (cyc < 64) begin
      actA[cyc] = move_active; strA[cyc] = step_strobe; offA[cyc] = int'(offset);
      comA[cyc] = commit; busyA[cyc] = busy; pvA[cyc] = pend_valid; dirA[cyc] = int'(move_dir);
    end
    if (commit) nCommit++;
    cyc++;
    {btn_right, btn_left, btn_down, btn_up} = b;
    {right_en, left_en, down_en, up_en} = e;
    rst = r;
    modelUpdate(b, e, r);
  endtask

  task automatic startTest();
    step(4'b0, 4'hF, 1'b1);
    repeat (2) step(4'b0, 4'hF, 1'b0);
    cyc = 0;
    nCommit = 0;
    for (int i = 0; i < 64; i++) begin
      actA[i] = 0; strA[i] = 0; offA[i] = 0; comA[i] = 0; busyA[i] = 0; pvA[i] = 0; dirA[i] = 0;
    end
  endtask

  initial begin
    logic [3:0] b, e;
    int rTmp;
    mIn = 0; mT = 0; mDir = DIR_UP; mPv = 0; mPd = DIR_UP;
    cyc = 0; nCommit = 0;
    repeat (2) @(posedge clk);

    // Test 1: right move timing
    startTest();
    step(4'b1000, 4'hF, 1'b0);
    repeat (24) step(4'b0, 4'hF, 1'b0);
    chk("t1_act_before", actA[0], 0);
    chk("t1_act_first",  actA[1], 1);
    chk("t1_act_last",   actA[16], 1);
    chk("t1_act_after",  actA[17], 0);
    chk("t1_strobe4",    strA[4], 1);
    chk("t1_strobe12",   strA[12], 1);
    chk("t1_strobe16",   strA[16], 0);
    chk("t1_off5",       offA[5], 2);
    chk("t1_off16",      offA[16], 6);
    chk("t1_commit17",   comA[17], 1);
    chk("t1_busy18",     busyA[18], 1);
    chk("t1_busy19",     busyA[19], 0);
    chk("t1_dir",        dirA[5], int'(DIR_RIGHT));
    chk("t1_ncommit",    nCommit, 1);

    // Test 2: disabled press is dropped
    startTest();
    step(4'b0001, 4'b1110, 1'b0);
    repeat (30) step(4'b0, 4'b1110, 1'b0);
    chk("t2_ncommit", nCommit, 0);
    chk("t2_busy1",   busyA[1], 0);
    chk("t2_act5",    actA[5], 0);

    // Test 3: simultaneous up+left picks up
    startTest();
    step(4'b0101, 4'hF, 1'b0);
    repeat (22) step(4'b0, 4'hF, 1'b0);
    chk("t3_dir",     dirA[2], int'(DIR_UP));
    chk("t3_ncommit", nCommit, 1);

    // Test 4: buffered left, dropped right
    startTest();
    step(4'b0010, 4'hF, 1'b0);
    repeat (4) step(4'b0, 4'hF, 1'b0);
    step(4'b0100, 4'hF, 1'b0);
    step(4'b1000, 4'hF, 1'b0);
    repeat (33) step(4'b0, 4'hF, 1'b0);
    chk("t4_pv5",      pvA[5], 0);
    chk("t4_pv6",      pvA[6], 1);
    chk("t4_act19",    actA[19], 1);
    chk("t4_dir19",    dirA[19], int'(DIR_LEFT));
    chk("t4_ncommit",  nCommit, 2);

    // Test 5: pending left disabled before settle
    startTest();
    step(4'b0010, 4'hF, 1'b0);
    repeat (4) step(4'b0, 4'hF, 1'b0);
    step(4'b0100, 4'hF, 1'b0);
    repeat (4) step(4'b0, 4'hF, 1'b0);
    repeat (25) step(4'b0, 4'b1011, 1'b0);
    chk("t5_pv18",     pvA[18], 1);
    chk("t5_pv19",     pvA[19], 0);
    chk("t5_busy19",   busyA[19], 0);
    chk("t5_ncommit",  nCommit, 1);

    // Test 6: reset mid-move, then a fresh move
    startTest();
    step(4'b1000, 4'hF, 1'b0);
    repeat (2) step(4'b0, 4'hF, 1'b0);
    step(4'b0001, 4'hF, 1'b0);
    repeat (5) step(4'b0, 4'hF, 1'b0);
    step(4'b0, 4'hF, 1'b1);
    repeat (2) step(4'b0, 4'hF, 1'b0);
    step(4'b0010, 4'hF, 1'b0);
    repeat (27) step(4'b0, 4'hF, 1'b0);
    chk("t6_off9",     offA[9], 4);
    chk("t6_pv9",      pvA[9], 1);
    chk("t6_off10",    offA[10], 0);
    chk("t6_busy10",   busyA[10], 0);
    chk("t6_pv10",     pvA[10], 0);
    chk("t6_commit29", comA[29], 1);
    chk("t6_ncommit",  nCommit, 1);

    // Randomized traffic against the model
    e = 4'hF;
    for (int i = 0; i < 4000; i++) begin
      rTmp = int'($urandom_range(0, 7));
      b = (rTmp == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 5) == 0) e = 4'($urandom);
      step(b, e, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
